// File: rtl/ext_irq_source_pkg.sv
// Shared constants, FSM state encoding and byte-merge helper for ext_irq_source.
package ext_irq_source_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    REQ   = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [1:0] ACK_OFS    = 2'd0;
  localparam logic [1:0] CTRL_OFS   = 2'd1;
  localparam logic [1:0] PERIOD_OFS = 2'd2;
  localparam logic [1:0] LAT_OFS    = 2'd3;

  localparam int EN_BIT   = 0;
  localparam int MODE_BIT = 1;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ext_irq_source_if.sv
// Data-side bus slice seen by ext_irq_source: address, byte enables, write and read data.
interface ext_irq_source_if;
  logic [31:0] addr;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output addr, output byteen, output wdata, input rdata);
  modport slave  (input addr, input byteen, input wdata, output rdata);
endinterface

// File: rtl/ext_irq_source_bus_regs.sv
// Address decode, PERIOD byte-merge and combinational read mux for the 4-word window.
module irq_bus_regs #(
  parameter logic [31:0] BASE  = 32'h0000_7F20,
  parameter int          CNT_W = 32
) (
  ext_irq_source_if.slave  bus,
  input  logic             i_interrupt,
  input  logic [1:0]       i_ctrl,
  input  logic [CNT_W-1:0] i_period,
  input  logic [CNT_W-1:0] i_lat,
  output logic             o_ack_wr,
  output logic             o_ctrl_wr,
  output logic             o_period_wr,
  output logic [CNT_W-1:0] o_period_merged
);
  import ext_irq_source_pkg::*;

  logic       w_hit;
  logic       w_wr;
  logic [1:0] w_ofs;
  logic       w_unused_addr;

  // The window is 16 bytes and 16-byte aligned, so the upper address bits select it.
  assign w_hit         = (bus.addr[31:4] == BASE[31:4]);
  assign w_ofs         = bus.addr[3:2];
  assign w_wr          = w_hit && (bus.byteen != 4'b0000);
  assign w_unused_addr = ^bus.addr[1:0];

  assign o_ack_wr    = w_wr && (w_ofs == ACK_OFS);
  assign o_ctrl_wr   = w_wr && (w_ofs == CTRL_OFS);
  assign o_period_wr = w_wr && (w_ofs == PERIOD_OFS);

  assign o_period_merged = CNT_W'(merge_bytes(32'(i_period), bus.wdata, bus.byteen));

  always_comb begin
    bus.rdata = '0;
    if (w_hit) begin
      case (w_ofs)
        ACK_OFS:    bus.rdata = {31'b0, i_interrupt};
        CTRL_OFS:   bus.rdata = {30'b0, i_ctrl};
        PERIOD_OFS: bus.rdata = 32'(i_period);
        LAT_OFS:    bus.rdata = 32'(i_lat);
        default:    bus.rdata = '0;
      endcase
    end
  end

endmodule

// File: rtl/ext_irq_source.sv
// External interrupt source: raises interrupt after a programmable delay, holds it
// until a store to ACK, and records the request-to-acknowledge latency.
module ext_irq_source #(
  parameter logic [31:0] BASE  = 32'h0000_7F20,
  parameter int          CNT_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  ext_irq_source_if.slave bus,
  output logic            interrupt
);
  import ext_irq_source_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           r_state;
  state_e           w_next;
  logic [1:0]       r_ctrl;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_lat;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_lat_run;
  logic             r_irq;

  logic             w_ack_wr;
  logic             w_ctrl_wr;
  logic             w_period_wr;
  logic [CNT_W-1:0] w_period_merged;
  logic             w_en_clr;
  logic             w_ack;
  logic             w_reload;
  logic [CNT_W-1:0] w_lat_inc;

  irq_bus_regs #(.BASE(BASE), .CNT_W(CNT_W)) u_regs (
    .bus             (bus),
    .i_interrupt     (r_irq),
    .i_ctrl          (r_ctrl),
    .i_period        (r_period),
    .i_lat           (r_lat),
    .o_ack_wr        (w_ack_wr),
    .o_ctrl_wr       (w_ctrl_wr),
    .o_period_wr     (w_period_wr),
    .o_period_merged (w_period_merged)
  );

  assign w_en_clr  = w_ctrl_wr && !bus.wdata[EN_BIT];
  assign w_ack     = w_ack_wr && (r_state == REQ);
  assign w_reload  = (w_next == DELAY) && (r_state != DELAY);
  assign w_lat_inc = (r_lat_run == CNT_MAX) ? CNT_MAX : r_lat_run + CNT_W'(1);
  assign interrupt = r_irq;

  // A CTRL store clearing EN wins over every other transition in the same cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (r_ctrl[EN_BIT]) w_next = (r_period != '0) ? DELAY : REQ;
      DELAY:   if (r_count <= CNT_W'(1)) w_next = REQ;
      REQ:     if (w_ack_wr) begin
                 if (r_ctrl[MODE_BIT]) w_next = (r_period != '0) ? DELAY : REQ;
                 else                  w_next = DONE;
               end
      DONE:    w_next = DONE;
      default: w_next = IDLE;
    endcase
    if (w_en_clr || !r_ctrl[EN_BIT]) w_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_ctrl    <= '0;
      r_period  <= '0;
      r_lat     <= '0;
      r_count   <= '0;
      r_lat_run <= '0;
      r_irq     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_irq   <= (w_next == REQ);
      if (w_ctrl_wr)   r_ctrl   <= bus.wdata[1:0];
      if (w_period_wr) r_period <= w_period_merged;
      if (w_ack)       r_lat    <= w_lat_inc;
      if (w_reload)              r_count <= r_period;
      else if (w_next == DELAY)  r_count <= r_count - CNT_W'(1);
      else                       r_count <= '0;
      r_lat_run <= ((r_state == REQ) && (w_next == REQ) && !w_ack) ? w_lat_inc : '0;
    end
  end

endmodule

// File: tb/tb_ext_irq_source.sv
// Randomised scenario bench for ext_irq_source: timing of rises, ACK latency,
// register map, byte enables, EN clear and reset behaviour.
module tb_ext_irq_source;
  import ext_irq_source_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_7F20;

  logic clk = 1'b0;
  logic reset;
  logic interrupt;

  int vectors     = 0;
  int miscompares = 0;
  logic [31:0] modelLat = 32'd0;

  ext_irq_source_if bus ();

  ext_irq_source #(.BASE(BASE), .CNT_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .interrupt (interrupt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [31:0] regAddr(input logic [1:0] ofs);
    return BASE + {28'd0, ofs, 2'b00};
  endfunction

  task automatic busWriteAddr(input logic [31:0] a, input logic [31:0] data, input logic [3:0] be);
    bus.addr   = a;
    bus.wdata  = data;
    bus.byteen = be;
    @(negedge clk);
    bus.byteen = 4'b0000;
    bus.wdata  = 32'd0;
  endtask

  task automatic busWrite(input logic [1:0] ofs, input logic [31:0] data);
    busWriteAddr(regAddr(ofs), data, 4'hF);
  endtask

  task automatic busReadAddr(input logic [31:0] a, output logic [31:0] data);
    bus.addr   = a;
    bus.byteen = 4'b0000;
    #1;
    data = bus.rdata;
  endtask

  task automatic busRead(input logic [1:0] ofs, output logic [31:0] data);
    busReadAddr(regAddr(ofs), data);
  endtask

  // Edges until interrupt is seen high; -1 when the bound expires.
  task automatic countToRise(input int limit, output int edges);
    edges = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (interrupt === 1'b1) begin
        edges = i;
        break;
      end
    end
  endtask

  task automatic holdCycles(input int n, output int highCount);
    highCount = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (interrupt === 1'b1) highCount++;
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    reset      = 1'b0;
    bus.addr   = 32'd0;
    bus.wdata  = 32'd0;
    bus.byteen = 4'b0000;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (interrupt !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_irq: got %b expected 0", interrupt);
    end
    for (int ofs = 0; ofs < 4; ofs++) begin
      busRead(2'(ofs), rd);
      vectors++;
      if (rd !== 32'd0) begin
        miscompares++;
        $display("[TB] FAIL reset_read ofs=%0d: got %h expected 0", ofs, rd);
      end
    end
  endtask

  task automatic test_oneshot();
    int p, d, e, h;
    logic [31:0] rd;
    for (int it = 0; it < 4; it++) begin
      if (it == 0)      begin p = 5; d = 7; end
      else if (it == 1) begin p = 0; d = $urandom_range(0, 4); end
      else              begin p = $urandom_range(1, 9); d = $urandom_range(0, 6); end
      busWrite(PERIOD_OFS, 32'(p));
      busWrite(CTRL_OFS, 32'd1);
      countToRise(40, e);
      vectors++;
      if (e != p + 1) begin
        miscompares++;
        $display("[TB] FAIL oneshot_rise P=%0d: got %0d edges expected %0d", p, e, p + 1);
      end
      busRead(ACK_OFS, rd);
      vectors++;
      if (rd !== 32'd1) begin
        miscompares++;
        $display("[TB] FAIL oneshot_ackread_high: got %h expected 1", rd);
      end
      holdCycles(d, h);
      vectors++;
      if (h != d) begin
        miscompares++;
        $display("[TB] FAIL oneshot_hold: got %0d high cycles expected %0d", h, d);
      end
      busWrite(ACK_OFS, $urandom);
      modelLat = 32'(d + 1);
      vectors++;
      if (interrupt !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL oneshot_drop: got %b expected 0", interrupt);
      end
      busRead(LAT_OFS, rd);
      vectors++;
      if (rd !== modelLat) begin
        miscompares++;
        $display("[TB] FAIL oneshot_lat: got %0d expected %0d", rd, modelLat);
      end
      holdCycles(2 * p + 8, h);
      vectors++;
      if (h != 0) begin
        miscompares++;
        $display("[TB] FAIL oneshot_done_quiet: got %0d high cycles expected 0", h);
      end
      busWrite(CTRL_OFS, 32'd0);
    end
  endtask

  task automatic test_periodic();
    int p, d, e, h;
    logic [31:0] rd;
    for (int round = 0; round < 2; round++) begin
      p = (round == 0) ? 3 : $urandom_range(1, 6);
      busWrite(PERIOD_OFS, 32'(p));
      busWrite(CTRL_OFS, 32'd3);
      countToRise(40, e);
      vectors++;
      if (e != p + 1) begin
        miscompares++;
        $display("[TB] FAIL periodic_first_rise: got %0d expected %0d", e, p + 1);
      end
      for (int rep = 0; rep < 4; rep++) begin
        d = (round == 0) ? 2 : $urandom_range(0, 5);
        holdCycles(d, h);
        vectors++;
        if (h != d) begin
          miscompares++;
          $display("[TB] FAIL periodic_hold rep=%0d: got %0d expected %0d", rep, h, d);
        end
        busWrite(ACK_OFS, 32'd0);
        modelLat = 32'(d + 1);
        vectors++;
        if (interrupt !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL periodic_drop rep=%0d: got %b expected 0", rep, interrupt);
        end
        busRead(LAT_OFS, rd);
        vectors++;
        if (rd !== modelLat) begin
          miscompares++;
          $display("[TB] FAIL periodic_lat rep=%0d: got %0d expected %0d", rep, rd, modelLat);
        end
        if (rep < 3) begin
          countToRise(40, e);
          vectors++;
          if (e != p) begin
            miscompares++;
            $display("[TB] FAIL periodic_rerise rep=%0d: got %0d expected %0d", rep, e, p);
          end
        end
      end
      busWrite(CTRL_OFS, 32'd0);
    end
  endtask

  task automatic test_period_update();
    int p2, e;
    busWrite(PERIOD_OFS, 32'd4);
    busWrite(CTRL_OFS, 32'd3);
    countToRise(40, e);
    busWrite(ACK_OFS, 32'd0);
    modelLat = 32'd1;
    p2 = $urandom_range(2, 7);
    busWrite(PERIOD_OFS, 32'(p2));
    countToRise(40, e);
    vectors++;
    if (e != 3) begin
      miscompares++;
      $display("[TB] FAIL period_update_running: got %0d expected 3", e);
    end
    busWrite(ACK_OFS, 32'd0);
    countToRise(40, e);
    vectors++;
    if (e != p2) begin
      miscompares++;
      $display("[TB] FAIL period_update_reload: got %0d expected %0d", e, p2);
    end
    busWrite(ACK_OFS, 32'd0);
    busWrite(CTRL_OFS, 32'd0);
  endtask

  task automatic test_byteen();
    logic [31:0] rd, model, data;
    logic [3:0]  be;
    busWrite(PERIOD_OFS, 32'h0000_0100);
    model = 32'h0000_0100;
    bus.addr   = regAddr(PERIOD_OFS);
    bus.wdata  = 32'hAABB_CC10;
    bus.byteen = 4'b0001;
    #1;
    rd = bus.rdata;
    vectors++;
    if (rd !== model) begin
      miscompares++;
      $display("[TB] FAIL read_during_write: got %h expected %h", rd, model);
    end
    @(negedge clk);
    bus.byteen = 4'b0000;
    model = 32'h0000_0110;
    busRead(PERIOD_OFS, rd);
    vectors++;
    if (rd !== model) begin
      miscompares++;
      $display("[TB] FAIL byteen_example: got %h expected %h", rd, model);
    end
    for (int k = 0; k < 5; k++) begin
      data = $urandom;
      be   = 4'($urandom_range(1, 15));
      busWriteAddr(regAddr(PERIOD_OFS), data, be);
      for (int b = 0; b < 4; b++) begin
        if (be[b]) model[8*b +: 8] = data[8*b +: 8];
      end
      busRead(PERIOD_OFS, rd);
      vectors++;
      if (rd !== model) begin
        miscompares++;
        $display("[TB] FAIL byteen_rand be=%b: got %h expected %h", be, rd, model);
      end
    end
    busWrite(CTRL_OFS, 32'hFFFF_FFFE);
    busRead(CTRL_OFS, rd);
    vectors++;
    if (rd !== 32'd2) begin
      miscompares++;
      $display("[TB] FAIL ctrl_readback: got %h expected 2", rd);
    end
    busWrite(CTRL_OFS, 32'd0);
  endtask

  task automatic test_en_clear();
    int p, e, h;
    logic [31:0] rd;
    p = $urandom_range(1, 5);
    busWrite(PERIOD_OFS, 32'(p));
    busWrite(CTRL_OFS, 32'd1);
    countToRise(40, e);
    holdCycles(2, h);
    busWrite(CTRL_OFS, 32'd0);
    vectors++;
    if (interrupt !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL en_clear_drop: got %b expected 0", interrupt);
    end
    busWrite(ACK_OFS, 32'd0);
    busRead(LAT_OFS, rd);
    vectors++;
    if (rd !== modelLat) begin
      miscompares++;
      $display("[TB] FAIL en_clear_lat_kept: got %0d expected %0d", rd, modelLat);
    end
    holdCycles(10, h);
    vectors++;
    if (h != 0) begin
      miscompares++;
      $display("[TB] FAIL en_clear_quiet: got %0d high cycles expected 0", h);
    end
  endtask

  task automatic test_out_of_window();
    logic [31:0] addrs [3];
    logic [31:0] rd;
    int h;
    addrs[0] = BASE + 32'h14;
    addrs[1] = BASE - 32'h0C;
    addrs[2] = 32'h0000_FF24;
    for (int i = 0; i < 3; i++) begin
      busWriteAddr(addrs[i], 32'd1, 4'hF);
      busReadAddr(addrs[i], rd);
      vectors++;
      if (rd !== 32'd0) begin
        miscompares++;
        $display("[TB] FAIL outside_read addr=%h: got %h expected 0", addrs[i], rd);
      end
    end
    busRead(CTRL_OFS, rd);
    vectors++;
    if (rd !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL outside_write_ignored: got CTRL %h expected 0", rd);
    end
    holdCycles(10, h);
    vectors++;
    if (h != 0) begin
      miscompares++;
      $display("[TB] FAIL outside_quiet: got %0d high cycles expected 0", h);
    end
  endtask

  task automatic test_reset_mid();
    int e, h;
    logic [31:0] rd;
    busWrite(PERIOD_OFS, 32'd10);
    busWrite(CTRL_OFS, 32'd1);
    repeat (9) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    holdCycles(20, h);
    vectors++;
    if (h != 0) begin
      miscompares++;
      $display("[TB] FAIL reset_delay_quiet: got %0d high cycles expected 0", h);
    end
    busRead(CTRL_OFS, rd);
    vectors++;
    if (rd !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_delay_ctrl: got %h expected 0", rd);
    end
    busWrite(PERIOD_OFS, 32'd2);
    busWrite(CTRL_OFS, 32'd3);
    countToRise(40, e);
    holdCycles(1, h);
    busWrite(ACK_OFS, 32'd0);
    modelLat = 32'd2;
    busRead(LAT_OFS, rd);
    vectors++;
    if (rd !== modelLat) begin
      miscompares++;
      $display("[TB] FAIL reset_req_lat_before: got %0d expected %0d", rd, modelLat);
    end
    countToRise(40, e);
    vectors++;
    if (e != 2) begin
      miscompares++;
      $display("[TB] FAIL reset_req_rise: got %0d expected 2", e);
    end
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (interrupt !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_req_drop: got %b expected 0", interrupt);
    end
    reset = 1'b1;
    modelLat = 32'd0;
    busRead(LAT_OFS, rd);
    vectors++;
    if (rd !== modelLat) begin
      miscompares++;
      $display("[TB] FAIL reset_req_lat_clear: got %0d expected 0", rd);
    end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_period_update();
    test_byteen();
    test_en_clear();
    test_out_of_window();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
